// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: ratio-update controller for the integer clock divider.
// New ratios arrive over a valid/ready handshake. Each real change is applied
// just after a falling edge of the fed-back divided clock while the divider is
// gated, so the divided clock never produces a runt pulse.
module clk_div_ctrl #(
    parameter logic [31:0] RESET_RATIO    = 32'd1,
    parameter int unsigned SETTLE_CYCLES  = 2,     // 1..255
    parameter int unsigned TIMEOUT_CYCLES = 1024   // 2..65535
) (
    input  logic        i_ref_clk,
    input  logic        i_rst_n,
    input  logic        i_en_req,
    input  logic        i_cfg_valid,
    input  logic [31:0] i_cfg_ratio,
    output logic        o_cfg_ready,
    input  logic        i_div_clk,
    output logic [31:0] o_div_ratio,
    output logic        o_clk_en,
    output logic        o_done,
    output logic        o_cfg_err,
    output logic        o_timeout
);

    localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        GATE,
        SETTLE
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] ratio_reg, ratio_next;
    logic [31:0] pending_reg, pending_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0]  settle_cnt_reg, settle_cnt_next;
    logic        gate_reg, gate_next;
    logic        prev_reg;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        timeout_reg, timeout_next;

    logic        fall_edge;
    logic        accept;
    logic [15:0] wait_inc;

    // Divided clock is a registered output of the divider, so a one-cycle
    // history is enough to see its falling edge.
    assign fall_edge = prev_reg & ~i_div_clk;
    assign accept    = i_cfg_valid && (state_reg == IDLE);
    // Saturating increment of the edge-wait counter.
    assign wait_inc  = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg : wait_cnt_reg + 16'd1;

    // Next-state and next-register logic for the update sequence.
    always_comb begin
        state_next      = state_reg;
        ratio_next      = ratio_reg;
        pending_next    = pending_reg;
        wait_cnt_next   = wait_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        gate_next       = gate_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        timeout_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (i_cfg_ratio == 32'd0) begin
                        err_next = 1'b1;
                    end else if (i_cfg_ratio == ratio_reg) begin
                        // Same ratio: nothing to switch, acknowledge at once.
                        done_next = 1'b1;
                    end else begin
                        pending_next  = i_cfg_ratio;
                        wait_cnt_next = 16'd0;
                        if (ratio_reg == 32'd1) begin
                            // Bypass output has no samplable edge; gate now.
                            state_next = GATE;
                            gate_next  = 1'b1;
                        end else begin
                            state_next = WAIT_EDGE;
                        end
                    end
                end
            end
            WAIT_EDGE: begin
                wait_cnt_next = wait_inc;
                if (fall_edge) begin
                    state_next = GATE;
                    gate_next  = 1'b1;
                end else if (wait_inc >= WAIT_LAST) begin
                    state_next   = GATE;
                    gate_next    = 1'b1;
                    timeout_next = 1'b1;
                end
            end
            GATE: begin
                ratio_next      = pending_reg;
                settle_cnt_next = SETTLE_INIT;
                state_next      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_reg <= 8'd1) begin
                    settle_cnt_next = 8'd0;
                    gate_next       = 1'b0;
                    done_next       = 1'b1;
                    state_next      = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gate_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            ratio_reg      <= RESET_RATIO;
            pending_reg    <= 32'd0;
            wait_cnt_reg   <= 16'd0;
            settle_cnt_reg <= 8'd0;
            gate_reg       <= 1'b0;
            prev_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ratio_reg      <= ratio_next;
            pending_reg    <= pending_next;
            wait_cnt_reg   <= wait_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            gate_reg       <= gate_next;
            prev_reg       <= i_div_clk;
            done_reg       <= done_next;
            err_reg        <= err_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign o_cfg_ready = (state_reg == IDLE);
    assign o_div_ratio = ratio_reg;
    assign o_clk_en    = i_en_req & ~gate_reg;
    assign o_done      = done_reg;
    assign o_cfg_err   = err_reg;
    assign o_timeout   = timeout_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: directed scenarios followed by randomized ratio
// updates, checked cycle by cycle against a transaction-level timing model.
module tb_clk_div_ctrl;

    localparam int S = 2;
    localparam int T = 1024;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en_req    = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_ratio = 32'd0;
    logic        div_clk   = 1'b0;
    logic        cfg_ready;
    logic [31:0] div_ratio;
    logic        clk_en;
    logic        done;
    logic        cfg_err;
    logic        timeout;

    clk_div_ctrl #(
        .RESET_RATIO   (32'd1),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_en_req   (en_req),
        .i_cfg_valid(cfg_valid),
        .i_cfg_ratio(cfg_ratio),
        .o_cfg_ready(cfg_ready),
        .i_div_clk  (div_clk),
        .o_div_ratio(div_ratio),
        .o_clk_en   (clk_en),
        .o_done     (done),
        .o_cfg_err  (cfg_err),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          div_mode    = 2;   // 0: held high, 1: random bits, 2: divider model
    bit          en_rand     = 1'b0;
    logic        div_prev    = 1'b0;
    logic [31:0] model_ratio = 32'd1;

    // Behavioural stand-in for clk_div: registered divided clock, high for
    // the first ratio/2 counts of each period, frozen while not enabled.
    longint unsigned mcnt = 0;
    logic            mclk = 1'b0;
    always @(posedge clk) begin
        if (clk_en) begin
            if (div_ratio <= 32'd1) begin
                mcnt <= 0;
                mclk <= 1'b0;
            end else begin
                mcnt <= (mcnt + 1 >= longint'(div_ratio)) ? 0 : mcnt + 1;
                mclk <= (((mcnt + 1 >= longint'(div_ratio)) ? 0 : mcnt + 1) < longint'(div_ratio / 2));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_cycle(input bit gate, input logic [31:0] ratio, input bit exp_done,
                             input bit ready, input bit to, input bit err);
        check("clk_en", 32'(clk_en), 32'(en_req & ~gate));
        check("div_ratio", div_ratio, ratio);
        check("cfg_ready", 32'(cfg_ready), 32'(ready));
        check("done", 32'(done), 32'(exp_done));
        check("timeout", 32'(timeout), 32'(to));
        check("cfg_err", 32'(cfg_err), 32'(err));
    endtask

    // Advance one reference clock and drive this cycle's divided clock / enable.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        div_prev = div_clk;
        case (div_mode)
            0:       div_clk = 1'b1;
            1:       div_clk = 1'($urandom_range(0, 1));
            default: div_clk = mclk;
        endcase
        if (en_rand) en_req = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_cycle(1'b0, model_ratio, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Offer one ratio in the current cycle (A) and follow it to completion.
    task automatic do_update(input logic [31:0] ratio, input bit rst_in_settle);
        int          a;
        int          e;
        int          c;
        bit          found;
        bit          to;
        logic [31:0] old;
        old = model_ratio;
        a   = cyc;
        check("ready_at_accept", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ratio = ratio;
        if (ratio == 32'd0 || ratio == old) begin
            tick();
            cfg_valid = 1'b0;
            chk_cycle(1'b0, old, ratio != 32'd0, 1'b1, 1'b0, ratio == 32'd0);
            $display("txn A=%0d ratio=%0h %s", a, ratio, (ratio == 32'd0) ? "rejected" : "no-op");
            return;
        end
        found = (old == 32'd1);
        e     = a;
        to    = 1'b0;
        for (int k = 0; k < T + S + 8; k++) begin
            tick();
            cfg_valid = 1'b0;
            c = cyc;
            if (!found) begin
                if (div_prev && !div_clk) begin
                    found = 1'b1;
                    e     = c;
                end else if (c == a + T - 1) begin
                    found = 1'b1;
                    e     = c;
                    to    = 1'b1;
                end
                chk_cycle(1'b0, old, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                chk_cycle((c >= e + 1) && (c <= e + S + 1), (c >= e + 2) ? ratio : old,
                          c == e + S + 2, c == e + S + 2, to && (c == e + 1), 1'b0);
                if (rst_in_settle && c == e + 3) begin
                    rst_n = 1'b0;
                    #1;
                    model_ratio = 32'd1;
                    chk_cycle(1'b0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
                    rst_n = 1'b1;
                    $display("txn A=%0d ratio=%0h reset during settle at cycle %0d", a, ratio, c);
                    idle(4);
                    return;
                end
                if (c == e + S + 2) begin
                    model_ratio = ratio;
                    $display("txn A=%0d ratio=%0h -> %0h edge=%0d timeout=%0d done=%0d",
                             a, old, ratio, e, to, c);
                    return;
                end
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL update_bound A=%0d observed=no_done expected=done_by_%0d", a, a + T + S + 8);
    endtask

    initial begin
        logic [31:0] r;
        int          sel;
        // Reset with enable requested.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_cycle(1'b0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_clk_en_high", 32'(clk_en), 32'd1);
        #2;
        rst_n = 1'b1;
        idle(3);
        en_rand = 1'b1;

        div_mode = 2;
        do_update(32'd5, 1'b0);     // bypass path from ratio 1
        idle(2);
        do_update(32'd2, 1'b0);     // edge wait at ratio 5
        idle(6);
        do_update(32'd4, 1'b0);     // running at 2, switch to 4
        do_update(32'd0, 1'b0);     // zero ratio rejected
        do_update(32'd4, 1'b0);     // same ratio is a no-op
        idle(3);
        do_update(32'd3, 1'b0);
        div_mode = 0;
        do_update(32'd2, 1'b0);     // no edge: timeout path
        div_mode = 2;
        idle(4);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       r = 32'd0;
                1:       r = model_ratio;
                2:       r = 32'd1;
                3:       r = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: r = $urandom_range(2, 8);
            endcase
            div_mode = (model_ratio > 32'd16) ? 1 : int'($urandom_range(1, 2));
            do_update(r, 1'b0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

        div_mode = 1;
        do_update(model_ratio + 32'd1, 1'b1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
